// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard, forwarding and flush controller for the pipelined MIPS core
//   clk, srst                      clock, synchronous active-high reset
//   enable_i                       pipeline advance (table holds when low)
//   id_valid_i, id_rs_i, id_rt_i,  ID instruction, sources and their use flags,
//   id_uses_rs_i, id_uses_rt_i,    resolved destination and decoded control
//   id_waddr_i, id_reg_write_i, id_mem_read_i
//   redirect_i                     taken branch/jump resolving in REDIRECT_STAGE
//   stall_o, bubble_ex_o           load-use hold of PC/IF-ID and ID/EXE bubble
//   flush_mask_o                   bit 0 = IF/ID, bit k+1 = register feeding stage k
//   fwd_sel_a_o, fwd_sel_b_o       0 = register file, k = stage k result
//   stall_count_o, flush_count_o   statistics, present only with HAZARD_STATS_EN
module pipe_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_FWD_STAGE = 2,
  parameter int REDIRECT_STAGE = 1,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic enable_i,
  input  logic id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic id_uses_rs_i,
  input  logic id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0] id_waddr_i,
  input  logic id_reg_write_i,
  input  logic id_mem_read_i,
  input  logic redirect_i,
  output logic stall_o,
  output logic bubble_ex_o,
  output logic [REDIRECT_STAGE+1:0] flush_mask_o,
  output logic [$clog2(FWD_DEPTH+1)-1:0] fwd_sel_a_o,
  output logic [$clog2(FWD_DEPTH+1)-1:0] fwd_sel_b_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);
  localparam int SEL_W = $clog2(FWD_DEPTH+1);
  logic [FWD_DEPTH:0] v_q, v_d, rw_q, rw_d, mr_q, mr_d;
  logic [FWD_DEPTH:0][REG_ADDR_W-1:0] wa_q, wa_d;
  logic [REG_ADDR_W-1:0] rs_q, rt_q;
  logic hazard;
  // Descending scan so the nearest producer overrides older ones.
  // Loads are skipped until their data exists.
  always_comb begin
    fwd_sel_a_o = '0;
    fwd_sel_b_o = '0;
    hazard = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (v_q[0] && v_q[k] && rw_q[k] && !(mr_q[k] && k < LOAD_FWD_STAGE)) begin
        if (wa_q[k] == rs_q && rs_q != '0) fwd_sel_a_o = SEL_W'(k);
        if (wa_q[k] == rt_q && rt_q != '0) fwd_sel_b_o = SEL_W'(k);
      end
    end
    for (int j = 0; j <= LOAD_FWD_STAGE - 2; j++) begin
      if (v_q[j] && rw_q[j] && mr_q[j] && wa_q[j] != '0 &&
          ((id_uses_rs_i && wa_q[j] == id_rs_i) || (id_uses_rt_i && wa_q[j] == id_rt_i)))
        hazard = 1'b1;
    end
  end
  assign stall_o = enable_i & id_valid_i & ~redirect_i & hazard;
  assign bubble_ex_o = stall_o;
  assign flush_mask_o = (enable_i && redirect_i) ? {1'b0, {(REDIRECT_STAGE+1){1'b1}}} : '0;
  // Younger instructions behind the resolving redirect are killed as they shift.
  always_comb begin
    v_d = {v_q[FWD_DEPTH-1:0], id_valid_i & ~stall_o & ~redirect_i};
    rw_d = {rw_q[FWD_DEPTH-1:0], id_reg_write_i};
    mr_d = {mr_q[FWD_DEPTH-1:0], id_mem_read_i};
    wa_d = {wa_q[FWD_DEPTH-1:0], id_waddr_i};
    for (int k = 1; k <= REDIRECT_STAGE; k++)
      if (redirect_i) v_d[k] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      v_q <= '0;
      rw_q <= '0;
      mr_q <= '0;
      wa_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
    end else if (enable_i) begin
      v_q <= v_d;
      rw_q <= rw_d;
      mr_q <= mr_d;
      wa_q <= wa_d;
      rs_q <= id_rs_i;
      rt_q <= id_rt_i;
    end
  end
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk) begin
    if (srst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_o && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (enable_i && redirect_i && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end
  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;
`else
  assign stall_count_o = '0;
  assign flush_count_o = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: vector table with scoreboard plus deep-pipeline load-use sequence
module tb_pipe_hazard_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic srst, en, idv, urs, urt, rw, mr, rd;
  logic [4:0] rs, rt, wa;
  logic st, bb, st3, bb3;
  logic [2:0] fm, fm3;
  logic [1:0] fa, fb, fa3, fb3;
  logic [15:0] sc, fc, sc3, fc3;
  int total = 0, bad = 0, sc_m = 0, fc_m = 0;
  typedef struct {
    logic en, rst, v;
    logic [4:0] rs, rt;
    logic urs, urt;
    logic [4:0] wa;
    logic rw, mr, rd, st;
    logic [2:0] fm;
    logic [1:0] fa, fb;
  } vec_t;
  vec_t tv[$];
  vec_t sb[$];
  vec_t e;
  pipe_hazard_unit dut (
    .clk(clk), .srst(srst), .enable_i(en), .id_valid_i(idv), .id_rs_i(rs), .id_rt_i(rt),
    .id_uses_rs_i(urs), .id_uses_rt_i(urt), .id_waddr_i(wa), .id_reg_write_i(rw),
    .id_mem_read_i(mr), .redirect_i(rd), .stall_o(st), .bubble_ex_o(bb), .flush_mask_o(fm),
    .fwd_sel_a_o(fa), .fwd_sel_b_o(fb), .stall_count_o(sc), .flush_count_o(fc)
  );
  pipe_hazard_unit #(.FWD_DEPTH(3), .LOAD_FWD_STAGE(3)) dut3 (
    .clk(clk), .srst(srst), .enable_i(en), .id_valid_i(idv), .id_rs_i(rs), .id_rt_i(rt),
    .id_uses_rs_i(urs), .id_uses_rt_i(urt), .id_waddr_i(wa), .id_reg_write_i(rw),
    .id_mem_read_i(mr), .redirect_i(rd), .stall_o(st3), .bubble_ex_o(bb3), .flush_mask_o(fm3),
    .fwd_sel_a_o(fa3), .fwd_sel_b_o(fb3), .stall_count_o(sc3), .flush_count_o(fc3)
  );
  function automatic vec_t mk(int en_, int rst_, int v_, int rs_, int rt_, int urs_, int urt_,
                              int wa_, int rw_, int mr_, int rd_, int st_, int fm_, int fa_, int fb_);
    vec_t r;
    r.en = en_[0]; r.rst = rst_[0]; r.v = v_[0]; r.rs = rs_[4:0]; r.rt = rt_[4:0];
    r.urs = urs_[0]; r.urt = urt_[0]; r.wa = wa_[4:0]; r.rw = rw_[0]; r.mr = mr_[0];
    r.rd = rd_[0]; r.st = st_[0]; r.fm = fm_[2:0]; r.fa = fa_[1:0]; r.fb = fb_[1:0];
    return r;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask
  task automatic drive(vec_t x);
    en = x.en; srst = x.rst; idv = x.v; rs = x.rs; rt = x.rt; urs = x.urs; urt = x.urt;
    wa = x.wa; rw = x.rw; mr = x.mr; rd = x.rd;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    repeat (2) tick();
    //        en rst v rs rt urs urt wa rw mr rd | st fm fa fb
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,1,2,1,1,3,1,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,3,5,1,1,4,1,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,1,0));
    tv.push_back(mk(1,0,1,1,3,1,0,3,1,1,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,3,3,1,1,4,1,0,0, 1,0,0,0));
    tv.push_back(mk(1,0,1,3,3,1,1,4,1,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,2,2));
    tv.push_back(mk(1,0,1,1,0,1,0,7,1,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,2,0,1,0,7,1,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,7,0,1,0,8,1,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,1,0));
    tv.push_back(mk(1,0,1,1,0,1,0,0,1,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,2,0,1,0,0,1,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,0,0,1,0,9,1,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,1,5,1,0,5,1,1,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,5,0,1,0,6,1,0,1, 0,3,0,0));
    tv.push_back(mk(1,0,1,5,0,1,0,6,1,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,1,6,1,0,6,1,1,0, 0,0,0,0));
    tv.push_back(mk(0,0,1,6,0,1,0,7,1,0,0, 0,0,0,2));
    tv.push_back(mk(0,0,1,6,0,1,0,7,1,0,1, 0,0,0,2));
    tv.push_back(mk(0,0,1,6,0,1,0,7,1,0,0, 0,0,0,2));
    tv.push_back(mk(1,0,1,6,0,1,0,7,1,0,0, 1,0,0,2));
    tv.push_back(mk(1,0,1,6,0,1,0,7,1,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,1,3,1,0,3,1,1,0, 0,0,2,0));
    tv.push_back(mk(1,1,1,3,3,1,1,4,1,0,0, 1,0,0,0));
    tv.push_back(mk(1,0,1,3,3,1,1,4,1,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      sb.push_back(tv[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d stall", i), 32'(st), 32'(e.st));
      chk($sformatf("v%0d bubble", i), 32'(bb), 32'(e.st));
      chk($sformatf("v%0d flush_mask", i), 32'(fm), 32'(e.fm));
      chk($sformatf("v%0d fwd_a", i), 32'(fa), 32'(e.fa));
      chk($sformatf("v%0d fwd_b", i), 32'(fb), 32'(e.fb));
      chk($sformatf("v%0d stall_count", i), 32'(sc), STATS ? sc_m : 0);
      chk($sformatf("v%0d flush_count", i), 32'(fc), STATS ? fc_m : 0);
      tick();
      if (e.rst) begin
        sc_m = 0;
        fc_m = 0;
      end else begin
        if (e.en && e.st) sc_m++;
        if (e.en && e.rd) fc_m++;
      end
    end
    drive(mk(1,1,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tick();
    drive(mk(1,0,1,1,3,1,0,3,1,1,0, 0,0,0,0));
    @(negedge clk);
    chk("d3 lw stall", 32'(st3), 0);
    tick();
    drive(mk(1,0,1,3,3,1,1,4,1,0,0, 0,0,0,0));
    @(negedge clk);
    chk("d3 use1 stall", 32'(st3), 1);
    chk("d3 use1 bubble", 32'(bb3), 1);
    tick();
    @(negedge clk);
    chk("d3 use2 stall", 32'(st3), 1);
    tick();
    @(negedge clk);
    chk("d3 use3 stall", 32'(st3), 0);
    tick();
    drive(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    @(negedge clk);
    chk("d3 fwd_a", 32'(fa3), 3);
    chk("d3 fwd_b", 32'(fb3), 3);
    chk("d3 stall_count", 32'(sc3), STATS ? 2 : 0);
    chk("d3 flush_mask", 32'(fm3), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
